// File: rtl/ccc_reset_sequencer_pkg.sv
// Shared types and constants for the CCC PLL supervisor / reset sequencer.
package ccc_seq_pkg;

    typedef enum logic [2:0] {
        PWRDN,
        WAIT_LOCK,
        FILTER,
        RELEASE,
        RUN,
        FAULT
    } seq_state_e;

    localparam int unsigned LOSS_W = 8;
    localparam logic [LOSS_W-1:0] LOSS_SAT = '1;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == LOSS_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ccc_reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the CCC / clock-domain consumers.
interface ccc_reset_sequencer_if #(
    parameter int unsigned NUM_OUT = 4
) ();

    logic                            PLL_LOCK;
    logic                            RESTART;
    logic [NUM_OUT-1:0]              EN_MASK;
    logic                            PLL_POWERDOWN_N;
    logic [NUM_OUT-1:0]              OUT_RESET;
    logic                            READY;
    logic                            FAULT;
    logic [ccc_seq_pkg::LOSS_W-1:0]  LOSS_COUNT;

    modport master (
        input  PLL_LOCK, RESTART, EN_MASK,
        output PLL_POWERDOWN_N, OUT_RESET, READY, FAULT, LOSS_COUNT
    );

    modport slave (
        output PLL_LOCK, RESTART, EN_MASK,
        input  PLL_POWERDOWN_N, OUT_RESET, READY, FAULT, LOSS_COUNT
    );

endinterface

// File: rtl/ccc_reset_sequencer_bit_sync2.sv
// Two-flop synchroniser for a single asynchronous level, with selectable reset value.
module bit_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/ccc_reset_sequencer.sv
// PLL supervisor and staggered per-domain reset release for the fabric CCC.
module ccc_reset_sequencer
    import ccc_seq_pkg::*;
#(
    parameter int unsigned NUM_OUT      = 4,
    parameter int unsigned PD_CYCLES    = 16,
    parameter int unsigned LOCK_FILTER  = 64,
    parameter int unsigned STAGGER      = 8,
    parameter int unsigned LOCK_TIMEOUT = 1000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    ccc_reset_sequencer_if.master  bus
);

    localparam int unsigned TW = $clog2(max4(PD_CYCLES, LOCK_FILTER, STAGGER, LOCK_TIMEOUT)) + 1;
    localparam int unsigned SW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] PD_LAST   = TW'(PD_CYCLES - 1);
    localparam logic [TW-1:0] FILT_LAST = TW'(LOCK_FILTER - 1);
    localparam logic [TW-1:0] STAG_LAST = TW'(STAGGER - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_OUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic lock_s;

    seq_state_e          state_q,   state_d;
    logic [TW-1:0]       timer_q,   timer_d;
    logic [SW-1:0]       slot_q,    slot_d;
    logic [RW-1:0]       retry_q,   retry_d;
    logic                pd_n_q,    pd_n_d;
    logic [NUM_OUT-1:0]  out_rst_q, out_rst_d;
    logic                ready_q,   ready_d;
    logic                fault_q,   fault_d;
    logic [LOSS_W-1:0]   loss_q,    loss_d;
    logic [RW-1:0]       retry_inc;

    bit_sync2 #(.RESET_VAL(1'b0)) u_lock_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (bus.PLL_LOCK),
        .q   (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        slot_d    = slot_q;
        retry_d   = retry_q;
        pd_n_d    = pd_n_q;
        out_rst_d = out_rst_q;
        ready_d   = ready_q;
        fault_d   = fault_q;
        loss_d    = loss_q;
        retry_inc = retry_q + 1'b1;

        if (bus.RESTART) begin
            state_d   = PWRDN;
            timer_d   = '0;
            slot_d    = '0;
            retry_d   = '0;
            pd_n_d    = 1'b0;
            out_rst_d = '1;
            ready_d   = 1'b0;
            fault_d   = 1'b0;
        end else begin
            unique case (state_q)
                PWRDN: begin
                    pd_n_d = 1'b0;
                    if (timer_q == PD_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                        pd_n_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Timeout outranks a lock that arrives on the same edge.
                    if (timer_q == TO_LAST) begin
                        retry_d = retry_inc;
                        timer_d = '0;
                        pd_n_d  = 1'b0;
                        if (retry_inc == RETRY_MAX) begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d = PWRDN;
                        end
                    end else if (lock_s) begin
                        state_d = FILTER;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                FILTER: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == FILT_LAST) begin
                        state_d = RELEASE;
                        timer_d = '0;
                        slot_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                RELEASE, RUN: begin
                    if (!lock_s) begin
                        state_d   = WAIT_LOCK;
                        timer_d   = '0;
                        out_rst_d = '1;
                        ready_d   = 1'b0;
                        loss_d    = sat_inc(loss_q);
                    end else if (state_q == RELEASE) begin
                        // Masked slots still take their interval so release timing is mask-independent.
                        if (timer_q == STAG_LAST) begin
                            timer_d = '0;
                            if (bus.EN_MASK[slot_q]) out_rst_d[slot_q] = 1'b0;
                            if (slot_q == SLOT_LAST) begin
                                state_d = RUN;
                                ready_d = 1'b1;
                            end else begin
                                slot_d = slot_q + 1'b1;
                            end
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                FAULT: begin
                    pd_n_d    = 1'b0;
                    out_rst_d = '1;
                    ready_d   = 1'b0;
                    fault_d   = 1'b1;
                end
                default: begin
                    state_d   = PWRDN;
                    timer_d   = '0;
                    pd_n_d    = 1'b0;
                    out_rst_d = '1;
                    ready_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= PWRDN;
            timer_q   <= '0;
            slot_q    <= '0;
            retry_q   <= '0;
            pd_n_q    <= 1'b0;
            out_rst_q <= '1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            slot_q    <= slot_d;
            retry_q   <= retry_d;
            pd_n_q    <= pd_n_d;
            out_rst_q <= out_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            loss_q    <= loss_d;
        end
    end

    assign bus.PLL_POWERDOWN_N = pd_n_q;
    assign bus.OUT_RESET       = out_rst_q;
    assign bus.READY           = ready_q;
    assign bus.FAULT           = fault_q;
    assign bus.LOSS_COUNT      = loss_q;

endmodule

// File: tb/tb_ccc_reset_sequencer.sv
// Directed bench for ccc_reset_sequencer at default parameters; expected values hand-derived.
module tb_ccc_reset_sequencer;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    ccc_reset_sequencer_if #(.NUM_OUT(4)) bus ();

    ccc_reset_sequencer #(
        .NUM_OUT      (4),
        .PD_CYCLES    (16),
        .LOCK_FILTER  (64),
        .STAGGER      (8),
        .LOCK_TIMEOUT (1000),
        .MAX_RETRY    (3)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pdn"},   32'(bus.PLL_POWERDOWN_N), 32'd0);
        check({tag, "_out"},   32'(bus.OUT_RESET),       32'hF);
        check({tag, "_ready"}, 32'(bus.READY),           32'd0);
        check({tag, "_fault"}, 32'(bus.FAULT),           32'd0);
        check({tag, "_loss"},  32'(bus.LOSS_COUNT),      32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.PLL_LOCK = 1'b0;
        bus.RESTART  = 1'b0;
        bus.EN_MASK  = 4'hF;
        tick(3);
        check_reset_vals("rst");
        rst = 1'b0;

        // Clean power-up
        tick(15); check("pd_hold", 32'(bus.PLL_POWERDOWN_N), 32'd0);
        tick(1);  check("pd_rise", 32'(bus.PLL_POWERDOWN_N), 32'd1);
        tick(20); bus.PLL_LOCK = 1'b1;
        tick(74); check("up_pre0",  32'(bus.OUT_RESET), 32'hF);
        tick(1);  check("up_ch0",   32'(bus.OUT_RESET), 32'hE);
                  check("up_rdy0",  32'(bus.READY),     32'd0);
        tick(7);  check("up_pre1",  32'(bus.OUT_RESET), 32'hE);
        tick(1);  check("up_ch1",   32'(bus.OUT_RESET), 32'hC);
        tick(8);  check("up_ch2",   32'(bus.OUT_RESET), 32'h8);
        tick(7);  check("up_rdy_pre", 32'(bus.READY),   32'd0);
        tick(1);  check("up_ch3",   32'(bus.OUT_RESET), 32'h0);
                  check("up_ready", 32'(bus.READY),     32'd1);
                  check("up_loss",  32'(bus.LOSS_COUNT), 32'd0);

        // Lock loss in RUN: three edges to all-reset
        bus.PLL_LOCK = 1'b0;
        tick(2);  check("loss_e2_out", 32'(bus.OUT_RESET), 32'h0);
                  check("loss_e2_rdy", 32'(bus.READY),     32'd1);
        tick(1);  check("loss_out",  32'(bus.OUT_RESET),       32'hF);
                  check("loss_rdy",  32'(bus.READY),           32'd0);
                  check("loss_cnt",  32'(bus.LOSS_COUNT),      32'd1);
                  check("loss_pdn",  32'(bus.PLL_POWERDOWN_N), 32'd1);

        // Relock with a one-cycle glitch inside FILTER
        bus.PLL_LOCK = 1'b1;
        tick(40); bus.PLL_LOCK = 1'b0;
        tick(1);  bus.PLL_LOCK = 1'b1;
        tick(34); check("gl_noearly", 32'(bus.OUT_RESET), 32'hF);
        tick(40); check("gl_pre0",    32'(bus.OUT_RESET), 32'hF);
        tick(1);  check("gl_ch0",     32'(bus.OUT_RESET), 32'hE);
        tick(24); check("gl_ch3",     32'(bus.OUT_RESET), 32'h0);
                  check("gl_ready",   32'(bus.READY),     32'd1);
                  check("gl_loss",    32'(bus.LOSS_COUNT), 32'd1);

        // Masked release
        bus.PLL_LOCK = 1'b0;
        tick(3);  check("mk_loss", 32'(bus.LOSS_COUNT), 32'd2);
        bus.EN_MASK  = 4'b1010;
        bus.PLL_LOCK = 1'b1;
        tick(82); check("mk_pre",   32'(bus.OUT_RESET), 32'hF);
        tick(1);  check("mk_ch1",   32'(bus.OUT_RESET), 32'hD);
        tick(15); check("mk_ch2",   32'(bus.OUT_RESET), 32'hD);
                  check("mk_rdy0",  32'(bus.READY),     32'd0);
        tick(1);  check("mk_ch3",   32'(bus.OUT_RESET), 32'h5);
                  check("mk_ready", 32'(bus.READY),     32'd1);
        bus.EN_MASK = 4'hF;

        // Loss counter saturation (298 more losses, 300 total)
        for (int unsigned i = 0; i < 298; i++) begin
            bus.PLL_LOCK = 1'b0;
            tick(3);
            if (i == 251) check("sat_254", 32'(bus.LOSS_COUNT), 32'd254);
            if (i == 252) check("sat_255", 32'(bus.LOSS_COUNT), 32'd255);
            bus.PLL_LOCK = 1'b1;
            tick(67);
        end
        check("sat_300", 32'(bus.LOSS_COUNT), 32'd255);
        tick(10); check("sat_rel_ch0", 32'(bus.OUT_RESET), 32'hE);

        // RESTART mid-RELEASE keeps LOSS_COUNT
        bus.RESTART  = 1'b1;
        bus.PLL_LOCK = 1'b0;
        tick(1);
        bus.RESTART  = 1'b0;
        check("rs_out",   32'(bus.OUT_RESET),       32'hF);
        check("rs_rdy",   32'(bus.READY),           32'd0);
        check("rs_pdn",   32'(bus.PLL_POWERDOWN_N), 32'd0);
        check("rs_loss",  32'(bus.LOSS_COUNT),      32'd255);

        // Timeout / retry / fault
        tick(15);  check("to_p1_lo",  32'(bus.PLL_POWERDOWN_N), 32'd0);
        tick(1);   check("to_p1_hi",  32'(bus.PLL_POWERDOWN_N), 32'd1);
        tick(999); check("to_w1",     32'(bus.PLL_POWERDOWN_N), 32'd1);
        tick(1);   check("to_p2_lo",  32'(bus.PLL_POWERDOWN_N), 32'd0);
                   check("to_p2_flt", 32'(bus.FAULT),           32'd0);
        tick(15);  check("to_p2_hold",32'(bus.PLL_POWERDOWN_N), 32'd0);
        tick(1);   check("to_p2_hi",  32'(bus.PLL_POWERDOWN_N), 32'd1);
        tick(999); check("to_w2",     32'(bus.PLL_POWERDOWN_N), 32'd1);
        tick(1);   check("to_p3_lo",  32'(bus.PLL_POWERDOWN_N), 32'd0);
        tick(15);  check("to_p3_hold",32'(bus.PLL_POWERDOWN_N), 32'd0);
        tick(1);   check("to_p3_hi",  32'(bus.PLL_POWERDOWN_N), 32'd1);
        tick(999); check("to_w3_pdn", 32'(bus.PLL_POWERDOWN_N), 32'd1);
                   check("to_w3_flt", 32'(bus.FAULT),           32'd0);
        tick(1);   check("flt_set",   32'(bus.FAULT),           32'd1);
                   check("flt_pdn",   32'(bus.PLL_POWERDOWN_N), 32'd0);
                   check("flt_out",   32'(bus.OUT_RESET),       32'hF);
                   check("flt_rdy",   32'(bus.READY),           32'd0);
        bus.PLL_LOCK = 1'b1;
        tick(50);  check("flt_stick", 32'(bus.FAULT),           32'd1);
                   check("flt_pdn2",  32'(bus.PLL_POWERDOWN_N), 32'd0);
                   check("flt_loss",  32'(bus.LOSS_COUNT),      32'd255);
        bus.PLL_LOCK = 1'b0;
        tick(3);

        // RESTART out of FAULT clears retries
        bus.RESTART = 1'b1;
        tick(1);
        bus.RESTART = 1'b0;
        check("rf_fault", 32'(bus.FAULT),           32'd0);
        check("rf_pdn",   32'(bus.PLL_POWERDOWN_N), 32'd0);
        check("rf_loss",  32'(bus.LOSS_COUNT),      32'd255);
        tick(15);  check("rf_hold",   32'(bus.PLL_POWERDOWN_N), 32'd0);
        tick(1);   check("rf_hi",     32'(bus.PLL_POWERDOWN_N), 32'd1);
        tick(1000);check("rf_to_pdn", 32'(bus.PLL_POWERDOWN_N), 32'd0);
                   check("rf_to_flt", 32'(bus.FAULT),           32'd0);
        tick(16);  check("rf_pd_hi",  32'(bus.PLL_POWERDOWN_N), 32'd1);

        // RESET mid-RELEASE
        bus.PLL_LOCK = 1'b1;
        tick(77);  check("rr_ch0", 32'(bus.OUT_RESET), 32'hE);
        rst = 1'b1;
        tick(1);   check_reset_vals("rr");
        tick(5);   check("rr_hold_pdn", 32'(bus.PLL_POWERDOWN_N), 32'd0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
